cdc_toggle_dest_endpoint: RTL



---
 rtl/cdc_toggle_dest_endpoint_if.sv | 33 +++
 rtl/cdc_toggle_dest_endpoint.sv | 88 ++++++++
 2 files changed

// File: rtl/cdc_toggle_dest_endpoint_if.sv
// rtl/cdc_toggle_dest_endpoint_if.sv - handshake and status bundle for the toggle CDC receive endpoint
interface cdc_toggle_dest_endpoint_if #(
   parameter int COUNT_W = 16
);
   logic               req_toggle_async;
   logic               ack_toggle;
   logic               dest_valid;
   logic               dest_ready;
   logic [COUNT_W-1:0] event_count;
   logic               overrun;
   logic               overrun_clr;

   // master: source toggle plus destination consumer; slave: the endpoint itself
   modport master (
      output req_toggle_async,
      output dest_ready,
      output overrun_clr,
      input  ack_toggle,
      input  dest_valid,
      input  event_count,
      input  overrun
   );

   modport slave (
      input  req_toggle_async,
      input  dest_ready,
      input  overrun_clr,
      output ack_toggle,
      output dest_valid,
      output event_count,
      output overrun
   );
endinterface

// File: rtl/cdc_toggle_dest_endpoint.sv
// rtl/cdc_toggle_dest_endpoint.sv - receive end of toggle req/ack CDC handshake
// Each synchronized request toggle becomes one valid/ready transfer, acked by an ack toggle.
module cdc_toggle_dest_endpoint #(
   parameter int SYNC_STAGES = 2,
   parameter int COUNT_W     = 16
) (
   input  logic                      dest_clk,
   input  logic                      dest_reset,
   cdc_toggle_dest_endpoint_if.slave bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      VALID = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_sync;
   logic                   req_sync_dly_q;
   logic                   edge_det;
   logic                   pending;
   logic                   ack_q, ack_d;
   logic [COUNT_W-1:0]     count_q, count_d;
   logic                   overrun_q, overrun_d;

   assign req_sync = sync_q[SYNC_STAGES-1];
   assign edge_det = req_sync ^ req_sync_dly_q;
   // Unacknowledged request exists whenever the two toggles disagree.
   assign pending  = req_sync ^ ack_q;

   always_ff @(posedge dest_clk) begin
      if (dest_reset) begin
         sync_q         <= '0;
         req_sync_dly_q <= 1'b0;
         state_q        <= IDLE;
         ack_q          <= 1'b0;
         count_q        <= '0;
         overrun_q      <= 1'b0;
      end else begin
         sync_q         <= {sync_q[SYNC_STAGES-2:0], bus.req_toggle_async};
         req_sync_dly_q <= req_sync;
         state_q        <= state_d;
         ack_q          <= ack_d;
         count_q        <= count_d;
         overrun_q      <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ack_d     = ack_q;
      count_d   = count_q;
      overrun_d = overrun_q;

      if (bus.overrun_clr) begin
         overrun_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (pending) begin
               state_d = VALID;
            end
         end
         VALID: begin
            // A toggle arriving while an event is still held is a violation; set beats clear.
            if (edge_det) begin
               overrun_d = 1'b1;
            end
            if (bus.dest_ready) begin
               ack_d   = ~ack_q;
               count_d = count_q + COUNT_W'(1);
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.dest_valid  = (state_q == VALID);
   assign bus.ack_toggle  = ack_q;
   assign bus.event_count = count_q;
   assign bus.overrun     = overrun_q;

endmodule
